addr_gen_queue: RTL

- Parametrised successor to the single-slot address unit.
- Each accepted request computes an effective address (base + offset, modulo 2^XLEN), classifies its alignment, and buffers the result with its load/store flag, destination register and instruction tag in a DEPTH-entry in-order queue.
- Sits between the issue stage and the memory/LSB interface.
- Uses valid/ready handshakes on both sides and a flush input for branch mispredict recovery.

---
 rtl/addr_gen_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/addr_gen_queue.sv
// Address-generation queue: computes base+offset per request, tags alignment faults,
// and holds results in a DEPTH-entry in-order FIFO between issue and memory.
module addr_gen_queue #(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 4,
  parameter int REG_W       = 3,
  parameter int DEPTH       = 4,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_base,
  input  logic [XLEN-1:0]            in_offset,
  input  logic                       in_is_load,
  input  logic [1:0]                 in_size,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [REG_W-1:0]           in_reg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_addr,
  output logic                       out_is_load,
  output logic [1:0]                 out_size,
  output logic [TAG_W-1:0]           out_tag,
  output logic [REG_W-1:0]           out_reg,
  output logic                       out_misaligned,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = XLEN + 1 + 2 + TAG_W + REG_W + 1;

  logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [ENTRY_W-1:0] entry_mem [DEPTH];

  logic [XLEN-1:0]    addr_next;
  logic               misaligned_next;
  logic [ENTRY_W-1:0] entry_next;
  logic [ENTRY_W-1:0] head_entry;
  logic               push, pop;

  assign addr_next = in_base + in_offset;

  generate
    if (ALIGN_CHECK != 0) begin : g_align
      always_comb begin
        misaligned_next = 1'b0;
        case (in_size)
          2'd0:    misaligned_next = 1'b0;
          2'd1:    misaligned_next = addr_next[0];
          2'd2:    misaligned_next = |addr_next[1:0];
          default: misaligned_next = 1'b1;  // reserved size is reported as a fault
        endcase
      end
    end else begin : g_no_align
      assign misaligned_next = 1'b0;
    end
  endgenerate

  assign entry_next = {addr_next, in_is_load, in_size, in_tag, in_reg, misaligned_next};

  // Ready looks only at registered occupancy, so a pop cannot free a slot the same cycle.
  assign in_ready  = (count_reg < CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst && push) entry_mem[wr_ptr_reg] <= entry_next;
  end

  assign head_entry = entry_mem[rd_ptr_reg];
  assign {out_addr, out_is_load, out_size, out_tag, out_reg, out_misaligned} = head_entry;
  assign count = count_reg;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && count_reg == CNT_W'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && count_reg == '0));

endmodule
